// File: rtl/cmerge_sync_sink_if.sv
// Handshake bundle between the upstream merge, the sink and its downstream consumer.
// The slave side is the sink; the master side is whoever drives the merge and consumes tokens.
interface cmerge_sync_sink_if;
  logic       i_drive;
  logic [1:0] i_validation_2;
  logic       o_free;
  logic       o_valid;
  logic       i_ready;
  logic       o_src;

  // Upstream: i_drive rise marks a token, i_validation_2 holds until o_free.
  // Downstream: head token moves on a cycle where o_valid & i_ready.
  modport slave (
    input  i_drive, i_validation_2, i_ready,
    output o_free, o_valid, o_src
  );

  modport master (
    output i_drive, i_validation_2, i_ready,
    input  o_free, o_valid, o_src
  );
endinterface

// File: rtl/cmerge_sync_sink.sv
// Sink for a drive/free arbiter-merge: captures tokens on i_drive edges, brings them into clk
// through a toggle synchronizer, queues source ids in a FWFT FIFO and counts tokens per source.
module cmerge_sync_sink #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  cmerge_sync_sink_if.slave            bus,
  output logic [$clog2(DEPTH+1)-1:0]   o_level,
  output logic [CNT_W-1:0]             o_cnt0,
  output logic [CNT_W-1:0]             o_cnt1,
  output logic                         o_protoErr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic                   tog_q;
  logic [1:0]             val_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   seen_q, seen_d;
  logic                   free_q, free_d;
  logic                   err_q, err_d;
  logic [AW-1:0]          wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]          level_q, level_d;
  logic [CNT_W-1:0]       cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic                   mem_q [DEPTH];

  logic sync_last, pending, id_ok, full, pop, push, consume;

  // r_val is deliberately not synchronized: the upstream holds it until o_free.
  always_ff @(posedge bus.i_drive or posedge rst) begin
    if (rst) begin
      tog_q <= 1'b0;
      val_q <= 2'b00;
    end else begin
      tog_q <= ~tog_q;
      val_q <= bus.i_validation_2;
    end
  end

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign pending   = sync_last ^ seen_q;
  assign id_ok     = (val_q == 2'b01) || (val_q == 2'b10);
  assign full      = (level_q == LW'(DEPTH));
  assign pop       = (level_q != '0) && bus.i_ready;
  assign push      = pending && id_ok && (!full || pop);
  assign consume   = push || (pending && !id_ok);

  always_comb begin
    seen_d  = seen_q;
    free_d  = consume;
    err_d   = err_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;

    if (consume) seen_d = sync_last;
    // A new toggle arriving while free is still high means a drive overtook its free.
    if ((pending && !id_ok) || (free_q && pending)) err_d = 1'b1;

    if (push) begin
      wr_d = wr_q + 1'b1;
      if (!val_q[1] && (cnt0_q != '1)) cnt0_d = cnt0_q + 1'b1;
      if ( val_q[1] && (cnt1_q != '1)) cnt1_d = cnt1_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      seen_q  <= 1'b0;
      free_q  <= 1'b0;
      err_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], tog_q};
      seen_q  <= seen_d;
      free_q  <= free_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= val_q[1];
  end

  assign bus.o_free  = free_q;
  assign bus.o_valid = (level_q != '0);
  assign bus.o_src   = (level_q != '0) & mem_q[rd_q];
  assign o_level     = level_q;
  assign o_cnt0      = cnt0_q;
  assign o_cnt1      = cnt1_q;
  assign o_protoErr  = err_q;

endmodule

// File: tb/tb_cmerge_sync_sink.sv
// Directed bench for cmerge_sync_sink: a scoreboard queue holds expected head sources,
// pushed when a well-formed token is driven and popped when the downstream handshake fires.
module tb_cmerge_sync_sink;

  logic       clk;
  logic       rst;
  logic [2:0] o_level;
  logic [3:0] o_cnt0, o_cnt1;
  logic       o_protoErr;

  int errors = 0;
  int checks = 0;
  int pop_cnt = 0;
  logic [0:0] exp_q[$];

  cmerge_sync_sink_if bus();

  cmerge_sync_sink #(.DEPTH(4), .SYNC_STAGES(2), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .o_level    (o_level),
    .o_cnt0     (o_cnt0),
    .o_cnt1     (o_cnt1),
    .o_protoErr (o_protoErr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_ready(input logic r);
    @(negedge clk); #1;
    bus.i_ready = r;
  endtask

  task automatic send(input logic [1:0] id);
    @(negedge clk); #1;
    bus.i_validation_2 = id;
    bus.i_drive = 1'b1;
    if (id == 2'b01 || id == 2'b10) exp_q.push_back(id[1]);
    #3 bus.i_drive = 1'b0;
  endtask

  task automatic wait_free(input int max_cyc, output bit got, output int lat);
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk); #1;
      if (bus.o_free) begin
        got = 1'b1;
        lat = i;
        break;
      end
    end
  endtask

  // scoreboard: compare every downstream pop against the expected queue
  initial begin
    logic [1:0] exp2;
    forever begin
      @(negedge clk); #3;
      if (!rst && bus.o_valid && bus.i_ready) begin
        exp2 = (exp_q.size() != 0) ? {1'b0, exp_q.pop_front()} : 2'b10;
        chk("pop_src", {31'b0, bus.o_src}, {30'b0, exp2});
        pop_cnt++;
      end
    end
  end

  initial begin
    bit got;
    int lat;
    int snap;

    rst = 1'b1;
    bus.i_drive = 1'b0;
    bus.i_validation_2 = 2'b00;
    bus.i_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_free",  bus.o_free, 0);
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_src",   bus.o_src, 0);
    chk("rst_level", o_level, 0);
    chk("rst_cnt0",  o_cnt0, 0);
    chk("rst_cnt1",  o_cnt1, 0);
    chk("rst_err",   o_protoErr, 0);
    rst = 1'b0;

    // single token from in0
    set_ready(1'b1);
    send(2'b01);
    wait_free(8, got, lat);
    chk("single_got_free", got, 1);
    chk("single_latency", lat, 3);
    chk("single_valid", bus.o_valid, 1);
    chk("single_src", bus.o_src, 0);
    @(negedge clk); #1;
    chk("single_free_pulse_end", bus.o_free, 0);
    chk("single_valid_end", bus.o_valid, 0);
    chk("single_cnt0", o_cnt0, 1);
    chk("single_cnt1", o_cnt1, 0);
    chk("single_err", o_protoErr, 0);

    // backpressure: four tokens fill the FIFO, the fifth is held off
    do_reset();
    set_ready(1'b0);
    for (int i = 0; i < 4; i++) begin
      send((i % 2 == 0) ? 2'b01 : 2'b10);
      wait_free(8, got, lat);
      chk("bp_fill_free", got, 1);
    end
    chk("bp_level_full", o_level, 4);
    chk("bp_head_src", bus.o_src, 0);
    send(2'b01);
    wait_free(8, got, lat);
    chk("bp_fifth_withheld", got, 0);
    chk("bp_level_held", o_level, 4);
    set_ready(1'b1);
    wait_free(4, got, lat);
    chk("bp_fifth_free", got, 1);
    chk("bp_fifth_latency", lat, 1);
    chk("bp_level_push_pop", o_level, 4);
    repeat (8) @(negedge clk);
    #1;
    chk("bp_drained_level", o_level, 0);
    chk("bp_drained_valid", bus.o_valid, 0);
    chk("bp_cnt0", o_cnt0, 3);
    chk("bp_cnt1", o_cnt1, 2);
    chk("bp_queue_empty", exp_q.size(), 0);
    chk("bp_err", o_protoErr, 0);

    // malformed id is consumed and flagged
    do_reset();
    chk("rst_clears_level", o_level, 0);
    send(2'b11);
    wait_free(8, got, lat);
    chk("bad_got_free", got, 1);
    chk("bad_latency", lat, 3);
    chk("bad_no_push", o_level, 0);
    chk("bad_cnt0", o_cnt0, 0);
    chk("bad_cnt1", o_cnt1, 0);
    chk("bad_err", o_protoErr, 1);
    repeat (5) @(negedge clk);
    #1;
    chk("bad_err_sticky", o_protoErr, 1);
    do_reset();
    chk("bad_err_cleared", o_protoErr, 0);

    // second drive one cycle after the first lands while free is high
    set_ready(1'b1);
    send(2'b01);
    send(2'b01);
    repeat (8) @(negedge clk);
    #1;
    chk("dbl_err", o_protoErr, 1);
    chk("dbl_cnt0", o_cnt0, 2);
    chk("dbl_level", o_level, 0);
    chk("dbl_queue_empty", exp_q.size(), 0);

    // counter saturation on in1
    do_reset();
    set_ready(1'b1);
    for (int i = 0; i < 17; i++) begin
      send(2'b10);
      wait_free(8, got, lat);
      chk("sat_free", got, 1);
    end
    repeat (3) @(negedge clk);
    #1;
    chk("sat_cnt1", o_cnt1, 15);
    chk("sat_cnt0", o_cnt0, 0);
    chk("sat_queue_empty", exp_q.size(), 0);

    // reset with two tokens queued and one in flight
    do_reset();
    set_ready(1'b0);
    send(2'b01);
    wait_free(8, got, lat);
    send(2'b10);
    wait_free(8, got, lat);
    chk("rmid_level_before", o_level, 2);
    send(2'b01);
    @(negedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("rmid_free",  bus.o_free, 0);
    chk("rmid_valid", bus.o_valid, 0);
    chk("rmid_src",   bus.o_src, 0);
    chk("rmid_level", o_level, 0);
    chk("rmid_cnt0",  o_cnt0, 0);
    chk("rmid_cnt1",  o_cnt1, 0);
    chk("rmid_err",   o_protoErr, 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    wait_free(6, got, lat);
    chk("rmid_no_spurious_free", got, 0);
    chk("rmid_level_after", o_level, 0);
    set_ready(1'b1);
    snap = pop_cnt;
    send(2'b10);
    wait_free(8, got, lat);
    chk("rmid_fresh_free", got, 1);
    chk("rmid_fresh_latency", lat, 3);
    repeat (4) @(negedge clk);
    #1;
    chk("rmid_one_pop", pop_cnt - snap, 1);
    chk("rmid_cnt1_after", o_cnt1, 1);
    chk("rmid_cnt0_after", o_cnt0, 0);
    chk("rmid_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
